// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and helper functions for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    localparam int MAX_REQ = 16;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Rotate-priority encoder: first set bit of valid after ptr, wrapping at n
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [3:0]         ptr,
                                           input int                 n);
        logic [4:0] idx;
        logic       found;
        rr_pick = '0;
        found   = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = 5'(ptr) + 5'(i);
            if (idx >= 5'(n)) idx = idx - 5'(n);
            if (i <= n && !found && valid[idx[3:0]]) begin
                rr_pick = idx[3:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin winner search starting after ptr_i
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  valid_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [ID_WIDTH-1:0] win_o,
    output logic                any_o
);

    assign win_o = ID_WIDTH'(rr_pick(MAX_REQ'(valid_i), 4'(ptr_i), NUM_REQ));
    assign any_o = |valid_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port; FIFO_ARB_BURST_EN adds burst locking
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  BURST_LEN  = 4,
    localparam int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                           i_clk,
    input  logic                           i_a_rst_n,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic                           o_fifo_wr_en,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] o_fifo_wr_data,
    input  logic                           i_fifo_full,
    output logic [ID_WIDTH-1:0]            o_grant_id
);

    if (BURST_LEN < 1 || NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_params
        $error("fifo_wr_arbiter: unsupported NUM_REQ/BURST_LEN");
    end

    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d, ptr_eff, pick_win, win;
    logic                  pick_any, any_req, beat;
    logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_data
        assign req_data[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_priority_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .valid_i (i_req_valid),
        .ptr_i   (ptr_eff),
        .win_o   (pick_win),
        .any_o   (pick_any)
    );

    // A beat transfers whenever someone wins and the FIFO has room; reset gates everything off
    assign beat           = i_a_rst_n && any_req && !i_fifo_full;
    assign o_req_ready    = beat ? (NUM_REQ'(1) << win) : '0;
    assign o_fifo_wr_en   = beat;
    assign o_fifo_wr_data = beat ? {win, req_data[win]} : '0;
    assign o_grant_id     = beat ? win : '0;

`ifdef FIFO_ARB_BURST_EN
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    arb_state_t          state_q, state_d;
    logic [ID_WIDTH-1:0] locked_q, locked_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                lock_hold;

    // While locked, the search restarts after the locked ID so a dropped lock hands over at once
    assign lock_hold = (state_q == LOCKED) && i_req_valid[locked_q];
    assign ptr_eff   = (state_q == LOCKED) ? locked_q : rr_ptr_q;
    assign win       = lock_hold ? locked_q : pick_win;
    assign any_req   = lock_hold || pick_any;

    // Burst FSM next state: extend a live lock, or start a new one on a completed beat
    always_comb begin
        state_d    = state_q;
        locked_d   = locked_q;
        beat_cnt_d = beat_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        if (lock_hold) begin
            if (beat) begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
                if (beat_cnt_d == CNT_W'(BURST_LEN)) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    rr_ptr_d   = locked_q;
                end
            end
        end else begin
            if (state_q == LOCKED) begin
                state_d    = IDLE;
                beat_cnt_d = '0;
                rr_ptr_d   = locked_q;
            end
            if (beat) begin
                rr_ptr_d = win;
                if (BURST_LEN > 1) begin
                    state_d    = LOCKED;
                    locked_d   = win;
                    beat_cnt_d = CNT_W'(1);
                end
            end
        end
    end

    // Burst FSM state registers
    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            state_q    <= IDLE;
            locked_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            locked_q   <= locked_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    assign ptr_eff  = rr_ptr_q;
    assign win      = pick_win;
    assign any_req  = pick_any;
    assign rr_ptr_d = beat ? win : rr_ptr_q;
`endif

    // Round-robin pointer; resetting to the last ID makes requester 0 first in line
    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) rr_ptr_q <= ID_WIDTH'(NUM_REQ - 1);
        else            rr_ptr_q <= rr_ptr_d;
    end

endmodule
